vmem_write_sched: RTL and testbench

Sequencer and arbiter for the write port of the text-mode character video memory that the VGA scan path reads.
- Two byte sources compete for the write port: keyboard ASCII and UART RX. A round-robin arbiter selects between them.
- The block keeps a cursor, interprets control characters and performs full-screen clears.
- It sits between the keyboard/UART front ends and the vmem write port, and exports the cursor position for cursor rendering.

---
 rtl/vmem_write_sched_pkg.sv | 27 ++
 rtl/vmem_write_sched_if.sv | 33 +++
 rtl/vmem_write_sched_rr_arb2.sv | 46 ++++
 rtl/vmem_write_sched.sv | 192 +++++++++++++++++++
 tb/tb_vmem_write_sched.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/vmem_write_sched_pkg.sv
// Shared definitions for the text-mode video memory write sequencer.
// Screen geometry is shared with vmem and the VGA text renderer.
package vmem_write_sched_pkg;

   localparam int COLS   = 70;
   localparam int ROWS   = 30;
   localparam int ADDR_W = 12;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_EXEC  = 2'd2
   } state_e;

   localparam logic [7:0] CH_SPACE    = 8'h20;
   localparam logic [7:0] CH_BS       = 8'h08;
   localparam logic [7:0] CH_LF       = 8'h0A;
   localparam logic [7:0] CH_CR       = 8'h0D;
   localparam logic [7:0] CH_FF       = 8'h0C;
   localparam logic [7:0] CH_PRINT_LO = 8'h20;
   localparam logic [7:0] CH_PRINT_HI = 8'h7E;

   function automatic logic is_print(input logic [7:0] c);
      return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
   endfunction

endpackage

// File: rtl/vmem_write_sched_if.sv
// Byte-source handshakes and the vmem write port.
// Handshake: a byte moves on a cycle where valid && ready. valid is held by the
// source until accepted (it may be withdrawn early); ready is a one-cycle pulse
// and is only ever raised towards a source whose valid is high.
interface vmem_write_sched_if
   import vmem_write_sched_pkg::*;
#(
   parameter int AW = ADDR_W
) ();

   logic          kb_valid;
   logic [7:0]    kb_data;
   logic          kb_ready;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          vm_we;
   logic [AW-1:0] vm_waddr;
   logic [7:0]    vm_wdata;

   // Byte sources and the vmem sink side.
   modport master (
      output kb_valid, kb_data, rx_valid, rx_data,
      input  kb_ready, rx_ready, vm_we, vm_waddr, vm_wdata
   );

   // Sequencer side.
   modport slave (
      input  kb_valid, kb_data, rx_valid, rx_data,
      output kb_ready, rx_ready, vm_we, vm_waddr, vm_wdata
   );

endinterface

// File: rtl/vmem_write_sched_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 = keyboard, bit 1 = UART.
// A grant is an accept: the granted request is valid by construction.
module vmem_write_sched_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   logic last_rx_q;
   logic last_rx_d;

   // Lone requester wins; on a tie the source not served last wins.
   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_rx_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
         endcase
      end
   end

   // Remember who was served, only when something was actually accepted.
   always_comb begin
      last_rx_d = last_rx_q;
      if (gnt_o[0]) begin
         last_rx_d = 1'b0;
      end else if (gnt_o[1]) begin
         last_rx_d = 1'b1;
      end
   end

   // History register; reset as "UART last" so the keyboard wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_rx_q <= 1'b1;
      end else begin
         last_rx_q <= last_rx_d;
      end
   end

endmodule

// File: rtl/vmem_write_sched.sv
// Write-port sequencer for the character video memory: arbitrates keyboard
// and UART bytes, interprets control codes, tracks the cursor and performs
// full-screen clears. Write outputs are loaded one edge ahead so the write
// of a byte shows up in the EXEC cycle right after its accept.
module vmem_write_sched #(
   parameter int COLS   = vmem_write_sched_pkg::COLS,
   parameter int ROWS   = vmem_write_sched_pkg::ROWS,
   parameter int ADDR_W = vmem_write_sched_pkg::ADDR_W
) (
   input  logic                         clk,
   input  logic                         rst,
   vmem_write_sched_if.slave            bus,
   input  logic                         clr,
   output logic [4:0]                   cur_row,
   output logic [6:0]                   cur_col,
   output logic                         busy,
   output vmem_write_sched_pkg::state_e state_dbg_o
);

   import vmem_write_sched_pkg::*;

   localparam logic [4:0]        ROW_LAST = 5'(ROWS - 1);
   localparam logic [6:0]        COL_LAST = 7'(COLS - 1);
   localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(ROWS * COLS - 1);

   state_e            state_q,   state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [4:0]        row_q,     row_d;
   logic [6:0]        col_q,     col_d;
   logic [ADDR_W-1:0] base_q,    base_d;
   logic [7:0]        char_q,    char_d;
   logic              we_q,      we_d;
   logic [ADDR_W-1:0] waddr_q,   waddr_d;
   logic [7:0]        wdata_q,   wdata_d;
   logic              busy_q,    busy_d;

   logic [1:0]        gnt;
   logic              arb_en;
   logic              accept;
   logic [7:0]        acc_data;
   logic [4:0]        row_inc;
   logic [ADDR_W-1:0] base_inc;
   logic [ADDR_W-1:0] cur_addr;

   // Accepts only happen in IDLE with no clear request and outside reset.
   assign arb_en   = (state_q == ST_IDLE) && !clr && !rst;
   assign accept   = |gnt;
   assign acc_data = gnt[1] ? bus.rx_data : bus.kb_data;

   // Row step with wrap to the top; row_base follows without a multiplier.
   assign row_inc  = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
   assign base_inc = (row_q == ROW_LAST) ? '0 : base_q + COLS_A;
   assign cur_addr = base_q + ADDR_W'(col_q);

   vmem_write_sched_rr_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i ({bus.rx_valid, bus.kb_valid}),
      .en_i  (arb_en),
      .gnt_o (gnt)
   );

   // Next state, cursor and the look-ahead write for the following cycle.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      row_d     = row_q;
      col_d     = col_q;
      base_d    = base_q;
      char_d    = char_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;

      case (state_q)
         ST_CLEAR: begin
            if (clr_cnt_q == CLR_LAST) begin
               state_d = ST_IDLE;
               row_d   = '0;
               col_d   = '0;
               base_d  = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
               we_d      = 1'b1;
               waddr_d   = clr_cnt_q + ADDR_W'(1);
               wdata_d   = CH_SPACE;
            end
         end

         ST_IDLE: begin
            if (clr) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
               we_d      = 1'b1;
               waddr_d   = '0;
               wdata_d   = CH_SPACE;
            end else if (accept) begin
               state_d = ST_EXEC;
               char_d  = acc_data;
               if (is_print(acc_data)) begin
                  we_d    = 1'b1;
                  waddr_d = cur_addr;
                  wdata_d = acc_data;
                  if (col_q == COL_LAST) begin
                     col_d  = '0;
                     row_d  = row_inc;
                     base_d = base_inc;
                  end else begin
                     col_d = col_q + 7'd1;
                  end
               end else if (acc_data == CH_LF || acc_data == CH_CR) begin
                  col_d  = '0;
                  row_d  = row_inc;
                  base_d = base_inc;
               end else if (acc_data == CH_BS) begin
                  if (col_q != 7'd0) begin
                     col_d   = col_q - 7'd1;
                     we_d    = 1'b1;
                     waddr_d = cur_addr - ADDR_W'(1);
                     wdata_d = CH_SPACE;
                  end else if (row_q != 5'd0) begin
                     row_d   = row_q - 5'd1;
                     col_d   = COL_LAST;
                     base_d  = base_q - COLS_A;
                     we_d    = 1'b1;
                     waddr_d = base_q - ADDR_W'(1);
                     wdata_d = CH_SPACE;
                  end
               end
            end
         end

         ST_EXEC: begin
            if (char_q == CH_FF) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = '0;
               we_d      = 1'b1;
               waddr_d   = '0;
               wdata_d   = CH_SPACE;
            end else begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset lands in CLEAR about to write address 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         row_q     <= '0;
         col_q     <= '0;
         base_q    <= '0;
         char_q    <= '0;
         we_q      <= 1'b1;
         waddr_q   <= '0;
         wdata_q   <= CH_SPACE;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         row_q     <= row_d;
         col_q     <= col_d;
         base_q    <= base_d;
         char_q    <= char_d;
         we_q      <= we_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.kb_ready = gnt[0];
   assign bus.rx_ready = gnt[1];
   // The write enable is held off while rst is high so no write lands mid-reset.
   assign bus.vm_we    = we_q & ~rst;
   assign bus.vm_waddr = waddr_q;
   assign bus.vm_wdata = wdata_q;
   assign cur_row      = row_q;
   assign cur_col      = col_q;
   assign busy         = busy_q;
   assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_vmem_write_sched.sv
// Directed bench for vmem_write_sched: clear sweep, single accept, arbitration
// order, cursor wrap, control codes and clear/reset interaction.
module tb_vmem_write_sched;
   import vmem_write_sched_pkg::*;

   logic   clk;
   logic   rst;
   logic   clr;
   logic [4:0] cur_row;
   logic [6:0] cur_col;
   logic   busy;
   state_e state_dbg;

   int n_assert = 0;
   int n_fail   = 0;
   int errs;

   vmem_write_sched_if bus ();

   vmem_write_sched dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .clr         (clr),
      .cur_row     (cur_row),
      .cur_col     (cur_col),
      .busy        (busy),
      .state_dbg_o (state_dbg)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [11:0] a, input logic [7:0] d);
      chk({tag, "_we"}, 32'(bus.vm_we), 32'(we));
      if (we) begin
         chk({tag, "_addr"}, 32'(bus.vm_waddr), 32'(a));
         chk({tag, "_data"}, 32'(bus.vm_wdata), 32'(d));
      end
   endtask

   task automatic chk_cur(input string tag, input int r, input int c);
      chk({tag, "_row"}, 32'(cur_row), 32'(r));
      chk({tag, "_col"}, 32'(cur_col), 32'(c));
   endtask

   // Offer one byte, wait (bounded) for its ready, pass the accept edge.
   // Returns in the EXEC cycle where the resulting write is visible.
   task automatic send(input logic use_rx, input logic [7:0] b);
      int waited;
      logic rdy;
      if (use_rx) begin
         bus.rx_valid = 1'b1; bus.rx_data = b;
      end else begin
         bus.kb_valid = 1'b1; bus.kb_data = b;
      end
      #1;
      waited = 0;
      rdy = use_rx ? bus.rx_ready : bus.kb_ready;
      while (!rdy && waited < 8) begin
         tick();
         waited++;
         rdy = use_rx ? bus.rx_ready : bus.kb_ready;
      end
      chk("ready_wait", 32'(rdy), 32'd1);
      tick();
      bus.kb_valid = 1'b0;
      bus.rx_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0;
      bus.kb_valid = 1'b0; bus.kb_data = 8'h00;
      bus.rx_valid = 1'b0; bus.rx_data = 8'h00;

      // reset
      tick();
      chk("rst_we", 32'(bus.vm_we), 32'd0);
      chk("rst_kb_ready", 32'(bus.kb_ready), 32'd0);
      tick();
      chk("rst_state", 32'(state_dbg), 32'(ST_CLEAR));
      rst = 1'b0;
      #1;

      // power-up clear sweep: 2100 writes of space
      chk_wr("sweep_first", 1'b1, 12'd0, 8'h20);
      errs = 0;
      for (int i = 0; i < 2100; i++) begin
         if (bus.vm_we !== 1'b1 || bus.vm_waddr !== 12'(i) || bus.vm_wdata !== 8'h20 || busy !== 1'b1)
            errs++;
         tick();
      end
      chk("sweep_errs", 32'(errs), 32'd0);
      chk("sweep_done_busy", 32'(busy), 32'd0);
      chk("sweep_done_we", 32'(bus.vm_we), 32'd0);
      chk_cur("sweep_done", 0, 0);

      // single keyboard 'A'
      bus.kb_valid = 1'b1; bus.kb_data = 8'h41;
      #1;
      chk("A_kb_ready", 32'(bus.kb_ready), 32'd1);
      chk("A_rx_ready", 32'(bus.rx_ready), 32'd0);
      tick();
      bus.kb_valid = 1'b0;
      #1;
      chk("A_ready_pulse", 32'(bus.kb_ready), 32'd0);
      chk_wr("A", 1'b1, 12'd0, 8'h41);
      chk_cur("A", 0, 1);
      tick();

      // backspace via UART at (0,1): blank address 0, back to (0,0)
      send(1'b1, CH_BS);
      chk_wr("bs_col", 1'b1, 12'd0, 8'h20);
      chk_cur("bs_col", 0, 0);
      tick();

      // both sources held: KB,RX,KB,RX
      bus.kb_valid = 1'b1; bus.kb_data = 8'h61;
      bus.rx_valid = 1'b1; bus.rx_data = 8'h62;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("rr_kb_ready", 32'(bus.kb_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_rx_ready", 32'(bus.rx_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
         tick();
         chk_wr("rr", 1'b1, 12'(k), (k % 2 == 0) ? 8'h61 : 8'h62);
         tick();
      end
      bus.kb_valid = 1'b0; bus.rx_valid = 1'b0;
      chk_cur("rr_end", 0, 4);

      // walk to (29,69), then 'x' writes 2099 and wraps to (0,0)
      for (int k = 0; k < 29; k++) begin send(1'b0, CH_LF); tick(); end
      for (int k = 0; k < 69; k++) begin send(1'b0, 8'h7A); tick(); end
      chk_cur("pre_wrap", 29, 69);
      send(1'b0, 8'h78);
      chk_wr("wrap_x", 1'b1, 12'd2099, 8'h78);
      chk_cur("wrap_x", 0, 0);
      tick();

      // LF at (5,10)
      for (int k = 0; k < 5; k++) begin send(1'b0, CH_LF); tick(); end
      for (int k = 0; k < 10; k++) begin send(1'b0, 8'h7A); tick(); end
      send(1'b0, CH_LF);
      chk_wr("lf", 1'b0, 12'd0, 8'h00);
      chk_cur("lf", 6, 0);
      tick();

      // 25 LFs: row 6 wraps through 29 to (1,0); then backspace across rows
      for (int k = 0; k < 25; k++) begin send(1'b0, CH_LF); tick(); end
      chk_cur("lf_wrap", 1, 0);
      send(1'b0, CH_BS);
      chk_wr("bs_row", 1'b1, 12'd69, 8'h20);
      chk_cur("bs_row", 0, 69);
      tick();
      for (int k = 0; k < 69; k++) begin send(1'b0, CH_BS); tick(); end
      chk_cur("bs_home", 0, 0);
      send(1'b0, CH_BS);
      chk_wr("bs_origin", 1'b0, 12'd0, 8'h00);
      chk_cur("bs_origin", 0, 0);
      tick();
      send(1'b1, 8'h07);
      chk_wr("bel", 1'b0, 12'd0, 8'h00);
      chk_cur("bel", 0, 0);
      tick();

      // clr beats a pending keyboard byte; reset mid-sweep restarts it
      clr = 1'b1;
      bus.kb_valid = 1'b1; bus.kb_data = 8'h51;
      #1;
      chk("clr_kb_ready", 32'(bus.kb_ready), 32'd0);
      tick();
      clr = 1'b0;
      #1;
      chk_wr("clr_start", 1'b1, 12'd0, 8'h20);
      chk("clr_busy", 32'(busy), 32'd1);
      errs = 0;
      for (int i = 0; i < 500; i++) begin
         if (bus.kb_ready !== 1'b0 || bus.vm_waddr !== 12'(i)) errs++;
         tick();
      end
      chk("clr_500_errs", 32'(errs), 32'd0);
      chk("clr_at_500", 32'(bus.vm_waddr), 32'd500);
      rst = 1'b1;
      #1;
      chk("mid_rst_we", 32'(bus.vm_we), 32'd0);
      chk("mid_rst_kb_ready", 32'(bus.kb_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk_wr("restart", 1'b1, 12'd0, 8'h20);
      errs = 0;
      for (int i = 0; i < 2099; i++) begin
         if (bus.kb_ready !== 1'b0 || bus.vm_we !== 1'b1 || bus.vm_waddr !== 12'(i)) errs++;
         tick();
      end
      chk("restart_errs", 32'(errs), 32'd0);
      chk("restart_last", 32'(bus.vm_waddr), 32'd2099);
      tick();
      chk("post_clr_kb_ready", 32'(bus.kb_ready), 32'd1);
      tick();
      bus.kb_valid = 1'b0;
      #1;
      chk_wr("post_clr_Q", 1'b1, 12'd0, 8'h51);
      chk_cur("post_clr_Q", 0, 1);
      tick();

      // form feed: no write in EXEC, then a clear sweep starts
      send(1'b1, CH_FF);
      chk_wr("ff_exec", 1'b0, 12'd0, 8'h00);
      tick();
      chk("ff_state", 32'(state_dbg), 32'(ST_CLEAR));
      chk_wr("ff_clear", 1'b1, 12'd0, 8'h20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
